frame_stager: RTL and testbench

FRAME_STAGER -- requirements
Module: frame_stager

---
 rtl/frame_stager.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_stager.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stager.sv
// Stages one request-sized payload frame into allocator-provided block memory, then emits a descriptor.
// Define FRAME_STAGER_LAST_CHECK_EN to cross-check i_data_last against the requested length.
module frame_stager #(
    parameter int unsigned MAU              = 32,
    parameter int unsigned NUM_BLOCKS       = 32,
    parameter int unsigned NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS)
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        i_req_valid,
    input  logic [NUM_BLOCKS_WIDTH-1:0] i_req_len,
    output logic                        o_req_ready,

    input  logic                        i_data_valid,
    input  logic [MAU-1:0]              i_data,
    input  logic                        i_data_last,
    output logic                        o_data_ready,

    output logic                        o_alloc_en,
    output logic [NUM_BLOCKS_WIDTH-1:0] o_request_size,
    input  logic [NUM_BLOCKS_WIDTH-1:0] i_alloc_addr,
    input  logic                        i_alloc_valid,
    input  logic                        i_alloc_err,

    output logic                        o_wr_en,
    output logic [NUM_BLOCKS_WIDTH-1:0] o_wr_addr,
    output logic [MAU-1:0]              o_wr_data,

    output logic                        o_desc_valid,
    output logic [NUM_BLOCKS_WIDTH-1:0] o_desc_addr,
    output logic [NUM_BLOCKS_WIDTH-1:0] o_desc_len,
    output logic                        o_desc_err,
    input  logic                        i_desc_ready
);

    localparam int unsigned AW = NUM_BLOCKS_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StAlloc,
        StWait,
        StWrite,
        StDrop,
        StDesc
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   offset_q, offset_d;
    logic            err_q, err_d;

    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [MAU-1:0]  wr_data_q;

    logic            beat_accept;
    logic            write_beat;
    logic            beat_final;
    logic            last_early;
    logic            last_missing;

    assign beat_accept = i_data_valid && ((state_q == StWrite) || (state_q == StDrop));
    assign write_beat  = beat_accept && (state_q == StWrite);
    assign beat_final  = (offset_q == (len_q - AW'(1)));

`ifdef FRAME_STAGER_LAST_CHECK_EN
    // Last flag must coincide exactly with the final counted beat.
    assign last_early   = i_data_last && !beat_final;
    assign last_missing = !i_data_last && beat_final;
`else
    assign last_early   = 1'b0;
    assign last_missing = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    state_d = (i_req_len != '0) ? StAlloc : StDesc;
                end
            end
            StAlloc: state_d = StWait;
            StWait: begin
                // An error response overrides a simultaneous valid.
                if (i_alloc_err) begin
                    state_d = StDrop;
                end else if (i_alloc_valid) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (write_beat) begin
                    if (last_early) begin
                        state_d = StDesc;
                    end else if (beat_final) begin
                        state_d = last_missing ? StDrop : StDesc;
                    end
                end
            end
            StDrop: begin
                if (beat_accept && i_data_last) begin
                    state_d = StDesc;
                end
            end
            StDesc: begin
                if (i_desc_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        o_req_ready    = 1'b0;
        o_alloc_en     = 1'b0;
        o_request_size = '0;
        o_data_ready   = 1'b0;
        o_desc_valid   = 1'b0;
        o_desc_addr    = '0;
        o_desc_len     = '0;
        o_desc_err     = 1'b0;
        unique case (state_q)
            StIdle: o_req_ready = 1'b1;
            StAlloc: begin
                o_alloc_en     = 1'b1;
                o_request_size = len_q;
            end
            StWait: o_request_size = len_q;
            StWrite, StDrop: o_data_ready = 1'b1;
            StDesc: begin
                o_desc_valid = 1'b1;
                o_desc_addr  = base_q;
                o_desc_len   = len_q;
                o_desc_err   = err_q;
            end
            default: ;
        endcase
    end

    // Frame context next-state
    always_comb begin
        len_d    = len_q;
        base_d   = base_q;
        offset_d = offset_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    len_d    = i_req_len;
                    base_d   = '0;
                    offset_d = '0;
                    err_d    = (i_req_len == '0);
                end
            end
            StWait: begin
                if (i_alloc_err) begin
                    err_d = 1'b1;
                end else if (i_alloc_valid) begin
                    base_d   = i_alloc_addr;
                    offset_d = '0;
                end
            end
            StWrite: begin
                if (write_beat) begin
                    offset_d = offset_q + AW'(1);
                    if (last_early || last_missing) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            base_q   <= '0;
            offset_q <= '0;
            err_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            err_q    <= err_d;
        end
    end

    // Memory write port, registered one cycle after beat acceptance; address wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= write_beat;
            if (write_beat) begin
                wr_addr_q <= base_q + offset_q;
                wr_data_q <= i_data;
            end
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;

endmodule

// File: tb/tb_frame_stager.sv
// Self-checking bench for frame_stager: directed scenarios plus randomized frames against a frame-level model.
module tb_frame_stager;

    localparam int MAU = 32;
    localparam int NB  = 32;
    localparam int AW  = $clog2(NB);

    logic           clk = 1'b0;
    logic           rst;
    logic           i_req_valid;
    logic [AW-1:0]  i_req_len;
    logic           o_req_ready;
    logic           i_data_valid;
    logic [MAU-1:0] i_data;
    logic           i_data_last;
    logic           o_data_ready;
    logic           o_alloc_en;
    logic [AW-1:0]  o_request_size;
    logic [AW-1:0]  i_alloc_addr;
    logic           i_alloc_valid;
    logic           i_alloc_err;
    logic           o_wr_en;
    logic [AW-1:0]  o_wr_addr;
    logic [MAU-1:0] o_wr_data;
    logic           o_desc_valid;
    logic [AW-1:0]  o_desc_addr;
    logic [AW-1:0]  o_desc_len;
    logic           o_desc_err;
    logic           i_desc_ready;

    int checks = 0;
    int errors = 0;

    int             mon_addr[$];
    logic [MAU-1:0] mon_data[$];
    int             alloc_pulses;
    logic [MAU-1:0] beat_data[64];
    bit             beat_last[64];

    frame_stager #(
        .MAU              (MAU),
        .NUM_BLOCKS       (NB),
        .NUM_BLOCKS_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .i_req_len      (i_req_len),
        .o_req_ready    (o_req_ready),
        .i_data_valid   (i_data_valid),
        .i_data         (i_data),
        .i_data_last    (i_data_last),
        .o_data_ready   (o_data_ready),
        .o_alloc_en     (o_alloc_en),
        .o_request_size (o_request_size),
        .i_alloc_addr   (i_alloc_addr),
        .i_alloc_valid  (i_alloc_valid),
        .i_alloc_err    (i_alloc_err),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_desc_valid   (o_desc_valid),
        .o_desc_addr    (o_desc_addr),
        .o_desc_len     (o_desc_len),
        .o_desc_err     (o_desc_err),
        .i_desc_ready   (i_desc_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            mon_addr.push_back(int'(o_wr_addr));
            mon_data.push_back(o_wr_data);
        end
        if (o_alloc_en === 1'b1) alloc_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", name, tag, obs, exp);
        end
    endtask

    // Frame-level outcome: writes performed, beats consumed, descriptor error flag.
    function automatic void model(input int len, input bit aerr, input int last_idx,
                                  output int nw, output int nc, output bit err);
        if (len == 0) begin
            nw = 0; nc = 0; err = 1'b1;
        end else if (aerr) begin
            nw = 0; nc = last_idx + 1; err = 1'b1;
        end else begin
`ifdef FRAME_STAGER_LAST_CHECK_EN
            if (last_idx < len - 1) begin
                nw = last_idx + 1; nc = nw; err = 1'b1;
            end else if (last_idx == len - 1) begin
                nw = len; nc = len; err = 1'b0;
            end else begin
                nw = len; nc = last_idx + 1; err = 1'b1;
            end
`else
            nw = len; nc = len; err = 1'b0;
`endif
        end
    endfunction

    task automatic run_frame(input string name, input int len, input int base, input int delay,
                             input bit aerr, input int last_idx, input int ready_delay,
                             input bit full_rate);
        int nw, nc, acc, cyc, n;
        bit err;
        for (int i = 0; i < 64; i++) begin
            beat_data[i] = $urandom;
            beat_last[i] = (i == last_idx);
        end
        model(len, aerr, last_idx, nw, nc, err);
        mon_addr.delete();
        mon_data.delete();
        alloc_pulses = 0;

        chk(name, "req_ready_idle", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_len   = AW'(len);
        @(negedge clk);
        i_req_valid = 1'b0;
        i_req_len   = '0;

        if (len != 0) begin
            chk(name, "alloc_en", o_alloc_en, 1);
            chk(name, "request_size", o_request_size, len);
            chk(name, "req_ready_busy", o_req_ready, 0);
            @(negedge clk);
            for (int i = 0; i < delay; i++) begin
                chk(name, "alloc_en_once", o_alloc_en, 0);
                chk(name, "request_size_hold", o_request_size, len);
                @(negedge clk);
            end
            i_alloc_err   = aerr;
            i_alloc_valid = aerr ? 1'($urandom_range(0, 1)) : 1'b1;
            i_alloc_addr  = AW'(base);
            @(negedge clk);
            i_alloc_valid = 1'b0;
            i_alloc_err   = 1'b0;
            i_alloc_addr  = '0;

            acc = 0;
            cyc = 0;
            while (acc < nc && cyc < 400) begin
                i_data_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                i_data       = beat_data[acc];
                i_data_last  = beat_last[acc];
                if (i_data_valid && o_data_ready === 1'b1) acc++;
                cyc++;
                @(negedge clk);
            end
            chk(name, "beats_consumed", acc, nc);
            if (full_rate) chk(name, "throughput_cycles", cyc, nc);
        end

        // Keep offering a beat during the descriptor phase; none may be accepted.
        i_data_valid = 1'b1;
        i_data       = '1;
        i_data_last  = 1'b1;
        cyc = 0;
        while (o_desc_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, "desc_valid", o_desc_valid, 1);
        for (int i = 0; i <= ready_delay; i++) begin
            if (!aerr) chk(name, "desc_addr", o_desc_addr, (len == 0) ? 0 : base % NB);
            chk(name, "desc_len", o_desc_len, len);
            chk(name, "desc_err", o_desc_err, err);
            chk(name, "desc_data_ready", o_data_ready, 0);
            if (i > 0) chk(name, "desc_hold_valid", o_desc_valid, 1);
            if (i == ready_delay) i_desc_ready = 1'b1;
            @(negedge clk);
        end
        i_desc_ready = 1'b0;
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
        i_data       = '0;
        chk(name, "desc_released", o_desc_valid, 0);
        chk(name, "back_to_idle", o_req_ready, 1);

        chk(name, "write_count", mon_addr.size(), nw);
        n = (mon_addr.size() < nw) ? mon_addr.size() : nw;
        for (int k = 0; k < n; k++) begin
            chk(name, "wr_addr", mon_addr[k], (base + k) % NB);
            chk(name, "wr_data", mon_data[k], beat_data[k]);
        end
        chk(name, "alloc_pulses", alloc_pulses, (len != 0) ? 1 : 0);
    endtask

    initial begin
        rst           = 1'b1;
        i_req_valid   = 1'b0;
        i_req_len     = '0;
        i_data_valid  = 1'b0;
        i_data        = '0;
        i_data_last   = 1'b0;
        i_alloc_addr  = '0;
        i_alloc_valid = 1'b0;
        i_alloc_err   = 1'b0;
        i_desc_ready  = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset", "alloc_en", o_alloc_en, 0);
        chk("reset", "wr_en", o_wr_en, 0);
        chk("reset", "desc_valid", o_desc_valid, 0);
        chk("reset", "desc_err", o_desc_err, 0);
        chk("reset", "data_ready", o_data_ready, 0);
        chk("reset", "wr_addr", o_wr_addr, 0);
        chk("reset", "wr_data", o_wr_data, 0);
        chk("reset", "desc_addr", o_desc_addr, 0);
        chk("reset", "desc_len", o_desc_len, 0);
        chk("reset", "request_size", o_request_size, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset", "req_ready_after", o_req_ready, 1);

        run_frame("basic_len4", 4, 8, 2, 1'b0, 3, 1, 1'b1);
        run_frame("wrap_len3", 3, 30, 0, 1'b0, 2, 0, 1'b1);
        run_frame("alloc_err", 5, 0, 1, 1'b1, 4, 0, 1'b1);
        run_frame("zero_len", 0, 0, 0, 1'b0, 0, 3, 1'b0);
        run_frame("early_last", 4, 12, 1, 1'b0, 1, 0, 1'b1);

        // Reset in the middle of a write burst.
        chk("mid_rst", "req_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_len   = AW'(4);
        @(negedge clk);
        i_req_valid   = 1'b0;
        @(negedge clk);
        i_alloc_valid = 1'b1;
        i_alloc_addr  = AW'(5);
        @(negedge clk);
        i_alloc_valid = 1'b0;
        i_data_valid  = 1'b1;
        i_data        = 32'hdead_0001;
        @(negedge clk);
        i_data        = 32'hdead_0002;
        @(negedge clk);
        i_data_valid  = 1'b0;
        chk("mid_rst", "wr_en_before", o_wr_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst", "wr_en", o_wr_en, 0);
        chk("mid_rst", "wr_addr", o_wr_addr, 0);
        chk("mid_rst", "wr_data", o_wr_data, 0);
        chk("mid_rst", "data_ready", o_data_ready, 0);
        chk("mid_rst", "desc_valid", o_desc_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst", "req_ready_after", o_req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst", "no_desc", o_desc_valid, 0);
            chk("mid_rst", "no_write", o_wr_en, 0);
            @(negedge clk);
        end
        run_frame("after_rst", 2, 17, 0, 1'b0, 1, 0, 1'b0);

        for (int f = 0; f < 24; f++) begin
            int len, lidx, r;
            r = $urandom_range(0, 9);
            len = (r == 0) ? 0 : ((r == 1) ? $urandom_range(9, 31) : $urandom_range(1, 8));
            r = $urandom_range(0, 9);
            if (len == 0) lidx = 0;
            else lidx = (r < 6) ? len - 1 : $urandom_range(0, len + 3);
            run_frame("random", len, $urandom_range(0, NB - 1), $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0), lidx, $urandom_range(0, 2),
                      1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
